// File: rtl/data_mem_param.sv
// data_mem_param: single-port word memory with registered reads, range checking
// and a multi-cycle clear-all sequence that zeroes one word per clock.
module data_mem_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              CLK,
  input  logic              ResetN,
  input  logic [ADDR_W-1:0] DataAddress,
  input  logic [1:0]        MemStatus,
  input  logic [DATA_W-1:0] DataIn,
  output logic [DATA_W-1:0] DataOut,
  output logic              DataValid,
  output logic              Busy,
  output logic              AddrErr
);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d, waddr;
  logic [DATA_W-1:0] dout_q, dout_d, wdata;
  logic valid_q, valid_d, err_q, err_d, we, in_range, last;
  logic [DATA_W-1:0] mem [DEPTH];
  // one extra bit so DEPTH = 2**ADDR_W compares correctly
  assign in_range = {1'b0, DataAddress} < (ADDR_W+1)'(DEPTH);
  assign last = cnt_q == ADDR_W'(DEPTH - 1);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    dout_d = dout_q;
    valid_d = 1'b0;
    err_d = 1'b0;
    we = 1'b0;
    waddr = DataAddress;
    wdata = DataIn;
    if (state_q == CLEAR) begin
      we = 1'b1;
      waddr = cnt_q;
      wdata = '0;
      cnt_d = last ? '0 : cnt_q + ADDR_W'(1);
      state_d = last ? IDLE : CLEAR;
    end else if (MemStatus == 2'b01) begin
      valid_d = 1'b1;
      err_d = !in_range;
      dout_d = in_range ? mem[DataAddress] : '0;
    end else if (MemStatus == 2'b10) begin
      we = in_range;
      err_d = !in_range;
    end else if (MemStatus == 2'b11) begin
      state_d = CLEAR;
      cnt_d = '0;
    end
  end
  // array has no reset; a reset edge suppresses any write, including a clear step
  always_ff @(posedge CLK)
    if (ResetN && we) mem[waddr] <= wdata;
  always_ff @(posedge CLK) begin
    if (!ResetN) begin
      state_q <= IDLE;
      cnt_q <= '0;
      dout_q <= '0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      dout_q <= dout_d;
      valid_q <= valid_d;
      err_q <= err_d;
    end
  end
  assign DataOut = dout_q;
  assign DataValid = valid_q;
  assign AddrErr = err_q;
  assign Busy = state_q == CLEAR;
endmodule

// File: doc/data_mem_param.md
DATA_MEM_PARAM -- requirements
Module: data_mem_param

Interface
REQ-001 Parameter: DATA_W, default 8, word width in bits.
REQ-002 Parameter: ADDR_W, default 8, address width in bits.
REQ-003 Parameter: DEPTH, default 256, number of words; legal range 2 to 2**ADDR_W.
REQ-004 Port: CLK  input  1  single clock; all state updates on rising edge.
REQ-005 Port: ResetN  input  1  reset, synchronous, active-low.
REQ-006 Port: DataAddress  input  ADDR_W  word pointer for read/write.
REQ-007 Port: MemStatus  input  2  command: 00 idle, 01 read, 10 write, 11 clear-all.
REQ-008 Port: DataIn  input  DATA_W  write data.
REQ-009 Port: DataOut  output  DATA_W  registered read data.
REQ-010 Port: DataValid  output  1  one-cycle pulse, DataOut updated by a read.
REQ-011 Port: Busy  output  1  high while clear sequence runs; commands ignored.
REQ-012 Port: AddrErr  output  1  one-cycle pulse, last read/write address >= DEPTH.

Function
REQ-013 Two states, IDLE and CLEAR; commands are sampled only in IDLE.
REQ-014 Read (01) at edge N with DataAddress < DEPTH: DataOut = mem[DataAddress] and DataValid = 1 after edge N (latency 1).
REQ-015 Write (10) at edge N with DataAddress < DEPTH: mem[DataAddress] = DataIn at edge N; DataOut and DataValid unchanged / 0.
REQ-016 Read at edge N+1 of an address written at edge N returns the new data.
REQ-017 Idle (00): no array access; DataValid = 0, AddrErr = 0; DataOut holds.
REQ-018 DataOut holds its last value between reads; DataValid is never high two cycles in a row unless reads are back-to-back.
REQ-019 Out-of-range read: DataOut = 0, DataValid = 1, AddrErr = 1 for one cycle.
REQ-020 Out-of-range write: array unchanged, AddrErr = 1 for one cycle.
REQ-021 Clear (11) at edge N in IDLE: state = CLEAR, Busy = 1 and clear counter = 0 after edge N.
REQ-022 In CLEAR: each edge writes 0 to mem[counter] and increments counter; after the edge writing DEPTH-1 state = IDLE, Busy = 0, counter = 0.
REQ-023 Clear duration: Busy high for exactly DEPTH cycles; first new command accepted at edge N+DEPTH+1.
REQ-024 In CLEAR: MemStatus, DataAddress, DataIn ignored (including 11); DataValid = 0, AddrErr = 0, DataOut holds.
REQ-025 Counter width ADDR_W; no wrap beyond DEPTH-1 for any legal DEPTH, including DEPTH = 2**ADDR_W.
REQ-026 Array is not initialised by configuration; contents change only via write or clear.

Reset
REQ-027 ResetN low at an edge overrides any command: DataOut = 0, DataValid = 0, Busy = 0, AddrErr = 0, state = IDLE, counter = 0.
REQ-028 Reset does not modify array contents; reset during CLEAR aborts it, leaving words already cleared at 0 and the rest unchanged.
REQ-029 First command after reset is accepted at the first edge with ResetN high.

Verification
REQ-030 Default params: write 8'hFF to addr 0, then read addr 0 -> DataOut = 8'hFF, DataValid = 1 one cycle after the read edge.
REQ-031 Write 8'h01 to addr 2 at edge N, read addr 2 at edge N+1 -> DataOut = 8'h01 after edge N+1; idle next -> DataValid = 0, DataOut stays 8'h01.
REQ-032 Fill addrs 0..3 with 8'hA5, issue 11 -> Busy high 256 cycles; write to addr 3 during Busy ignored; after Busy falls, read addrs 0..3 -> 8'h00 each.
REQ-033 DEPTH = 200 instance: read addr 8'd200 -> DataOut = 0, DataValid = 1, AddrErr = 1; write 8'h55 to addr 8'd250 -> AddrErr = 1, no array change.
REQ-034 Write 8'h3C to addrs 0 and 100, start clear, assert ResetN low at cycle 10 of Busy -> Busy = 0, DataOut = 0 next edge; read addr 0 -> 8'h00, addr 100 -> 8'h3C.
REQ-035 DATA_W = 16, ADDR_W = 4, DEPTH = 16: write 16'hFFFF to addr 15, read -> 16'hFFFF; clear -> Busy high exactly 16 cycles, addr 15 reads 16'h0000.
